// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: single-port word memory with byte-lane writes, programmable
// wait states and a two-cycle ERROR response for bad size/alignment or a masked window.
module ahb_sram_slave #(
  parameter int unsigned          ADDR_W      = 32,
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          MEM_AW      = 10,
  parameter int unsigned          WAIT_STATES = 0,
  parameter logic [ADDR_W-1:0]    ERR_BASE    = '0,
  parameter logic [ADDR_W-1:0]    ERR_MASK    = '0
) (
  input  logic              hclk_i,
  input  logic              hresetn_i,
  input  logic              hsel_i,
  input  logic [ADDR_W-1:0] haddr_i,
  input  logic [1:0]        htrans_i,
  input  logic              hwrite_i,
  input  logic [2:0]        hsize_i,
  input  logic [2:0]        hburst_i,
  input  logic [3:0]        hprot_i,
  input  logic [DATA_W-1:0] hwdata_i,
  input  logic              hready_i,
  output logic              hreadyout_o,
  output logic [1:0]        hresp_o,
  output logic [DATA_W-1:0] hrdata_o
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned DEPTH = 2 ** MEM_AW;

  typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              dphase_q, dphase_d;   // OKAY data phase completes this cycle
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [2:0]        size_q;
  logic [DATA_W-1:0] hrdata_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              can_accept, accept, complete;
  logic              size_err, align_err, win_err, xfer_err;
  logic [ADDR_W-1:0] align_mask;
  logic [MEM_AW-1:0] idx_q;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] mem_rdata;

  // Only states that drive HREADYOUT=1 can take a new address phase.
  assign can_accept = (state_q == StIdle) || (state_q == StErr2);
  assign accept     = hsel_i && hready_i && htrans_i[1] && can_accept;
  assign complete   = (state_q == StIdle) && dphase_q;

  assign align_mask = (ADDR_W'(1) << hsize_i) - ADDR_W'(1);
  assign size_err   = hsize_i > 3'(OFF_W);
  assign align_err  = |(haddr_i & align_mask);
  assign win_err    = (ERR_MASK != '0) && ((haddr_i & ERR_MASK) == ERR_BASE);
  assign xfer_err   = size_err || align_err || win_err;

  assign idx_q     = addr_q[MEM_AW+OFF_W-1:OFF_W];
  assign mem_rdata = mem[idx_q];

  // State register.
  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      dphase_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dphase_q <= dphase_d;
    end
  end

  // Next-state logic: accept, wait countdown, two-cycle error.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dphase_d = 1'b0;
    unique case (state_q)
      StIdle, StErr2: begin
        state_d = StIdle;
        if (accept) begin
          if (xfer_err) begin
            state_d = StErr1;
          end else if (WAIT_STATES != 0) begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES);
          end else begin
            dphase_d = 1'b1;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d    = '0;
          state_d  = StIdle;
          dphase_d = 1'b1;
        end
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
  end

  // Output decode from state.
  always_comb begin
    hreadyout_o = 1'b1;
    hresp_o     = 2'b00;
    unique case (state_q)
      StIdle:  ;
      StWait:  hreadyout_o = 1'b0;
      StErr1: begin
        hreadyout_o = 1'b0;
        hresp_o     = 2'b01;
      end
      StErr2:  hresp_o = 2'b01;
      default: ;
    endcase
  end

  // Address-phase capture and read-data holding register.
  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      hrdata_q <= '0;
    end else begin
      if (complete && !write_q) hrdata_q <= mem_rdata;
      if (accept) begin
        addr_q  <= haddr_i;
        write_q <= hwrite_i;
        size_q  <= hsize_i;
        // Errored reads return zero; this wins over a read completing at the same edge.
        if (xfer_err && !hwrite_i) hrdata_q <= '0;
      end
    end
  end

  // Byte enables from size and low address bits (transfer already known aligned).
  always_comb begin
    int unsigned lane;
    int unsigned nbytes;
    be     = '0;
    lane   = int'(addr_q[OFF_W-1:0]);
    nbytes = 1 << size_q;
    for (int b = 0; b < NB; b++) begin
      be[b] = (b >= lane) && (b < lane + nbytes);
    end
  end

  // Memory write at the completion edge; contents are intentionally not reset.
  always_ff @(posedge hclk_i) begin
    if (complete && write_q) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[idx_q][8*b +: 8] <= hwdata_i[8*b +: 8];
      end
    end
  end

  // Read data is combinational from the array during completion so a write committed at
  // the previous edge is visible immediately.
  assign hrdata_o = (complete && !write_q) ? mem_rdata : hrdata_q;

  logic unused_ok;
  assign unused_ok = ^{hburst_i, hprot_i, addr_q};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: three instances (WAIT_STATES 0/2/3, the first with an error
// window at 0x8000/0xF000) share one master; each slave's HREADY loops back from HREADYOUT.
module tb_ahb_sram_slave;

  logic        clk;
  logic        rst_n;
  logic [2:0]  hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;

  logic        rdy0, rdy1, rdy2;
  logic [1:0]  resp0, resp1, resp2;
  logic [31:0] rdata0, rdata1, rdata2;

  int          cur;
  logic        rdy;
  logic [1:0]  resp;
  logic [31:0] rdata;

  int          checks;
  int          failures;
  int          ws [3] = '{0, 2, 3};
  logic [31:0] mdl [3][1024];
  logic [31:0] sb [$];

  assign rdy   = (cur == 0) ? rdy0   : (cur == 1) ? rdy1   : rdy2;
  assign resp  = (cur == 0) ? resp0  : (cur == 1) ? resp1  : resp2;
  assign rdata = (cur == 0) ? rdata0 : (cur == 1) ? rdata1 : rdata2;

  ahb_sram_slave #(
    .WAIT_STATES(0), .ERR_BASE(32'h0000_8000), .ERR_MASK(32'h0000_F000)
  ) u_dut0 (
    .hclk_i(clk), .hresetn_i(rst_n), .hsel_i(hsel[0]), .haddr_i(haddr), .htrans_i(htrans),
    .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(3'b000), .hprot_i(4'b0011),
    .hwdata_i(hwdata), .hready_i(rdy0), .hreadyout_o(rdy0), .hresp_o(resp0),
    .hrdata_o(rdata0)
  );

  ahb_sram_slave #(.WAIT_STATES(2)) u_dut1 (
    .hclk_i(clk), .hresetn_i(rst_n), .hsel_i(hsel[1]), .haddr_i(haddr), .htrans_i(htrans),
    .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(3'b000), .hprot_i(4'b0011),
    .hwdata_i(hwdata), .hready_i(rdy1), .hreadyout_o(rdy1), .hresp_o(resp1),
    .hrdata_o(rdata1)
  );

  ahb_sram_slave #(.WAIT_STATES(3)) u_dut2 (
    .hclk_i(clk), .hresetn_i(rst_n), .hsel_i(hsel[2]), .haddr_i(haddr), .htrans_i(htrans),
    .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(3'b000), .hprot_i(4'b0011),
    .hwdata_i(hwdata), .hready_i(rdy2), .hreadyout_o(rdy2), .hresp_o(resp2),
    .hrdata_o(rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'h3FF);
  endfunction

  // Little-endian lane update of the reference memory.
  task automatic mdl_write(input int d, input logic [31:0] a, input logic [2:0] sz,
                           input logic [31:0] wd);
    int lo;
    int n;
    lo = int'(a[1:0]);
    n  = 1 << sz;
    for (int b = 0; b < 4; b++) begin
      if (b >= lo && b < lo + n) mdl[d][widx(a)][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  task automatic bus_idle();
    hsel   = 3'b000;
    htrans = 2'b00;
  endtask

  // One non-pipelined transfer. Entered and left just after a rising edge.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input bit err);
    int lows;
    bit done;
    lows = 0;
    done = 1'b0;
    cur    = d;
    hsel   = 3'b000;
    hsel[d] = 1'b1;
    haddr  = a;
    htrans = 2'b10;
    hwrite = wr;
    hsize  = sz;
    if (!wr) sb.push_back(err ? 32'h0 : mdl[d][widx(a)]);
    @(posedge clk); #1;
    bus_idle();
    hwdata = wd;
    if (err) begin
      @(negedge clk);
      chk("err1_ready", 32'(rdy), 32'd0);
      chk("err1_resp", 32'(resp), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("err2_ready", 32'(rdy), 32'd1);
      chk("err2_resp", 32'(resp), 32'd1);
      if (!wr) chk("err_rdata", rdata, sb.pop_front());
    end else begin
      for (int i = 0; i < 20 && !done; i++) begin
        @(negedge clk);
        if (rdy) begin
          done = 1'b1;
        end else begin
          lows++;
          chk("wait_resp", 32'(resp), 32'd0);
          @(posedge clk); #1;
        end
      end
      chk("complete_seen", 32'(done), 32'd1);
      chk("wait_cycles", 32'(lows), 32'(ws[d]));
      chk("okay_resp", 32'(resp), 32'd0);
      if (wr) mdl_write(d, a, sz, wd);
      else    chk("rdata", rdata, sb.pop_front());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cur      = 0;
    rst_n    = 1'b0;
    hsel     = 3'b000;
    haddr    = '0;
    htrans   = 2'b00;
    hwrite   = 1'b0;
    hsize    = 3'd2;
    hwdata   = '0;

    // Reset values on every instance.
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      cur = d;
      #1;
      chk("rst_ready", 32'(rdy), 32'd1);
      chk("rst_resp", 32'(resp), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // WS=0: write then read of 0x10 back-to-back; no stall, data one cycle after address.
    cur = 0; hsel = 3'b001; haddr = 32'h10; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    hwrite = 1'b0; hwdata = 32'hDEAD_BEEF;
    mdl_write(0, 32'h10, 3'd2, 32'hDEAD_BEEF);
    sb.push_back(mdl[0][widx(32'h10)]);
    @(negedge clk);
    chk("raw_wr_ready", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    chk("raw_rd_ready", 32'(rdy), 32'd1);
    chk("raw_rd_resp", 32'(resp), 32'd0);
    chk("raw_rd_data", rdata, sb.pop_front());
    @(posedge clk); #1;

    // Back-to-back SEQ word writes to 0x0/0x4/0x8 with no idle cycles.
    begin
      logic [31:0] seqd [3] = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003};
      for (int i = 0; i < 4; i++) begin
        if (i < 3) begin
          hsel = 3'b001; haddr = 32'(i * 4); htrans = (i == 0) ? 2'b10 : 2'b11;
          hwrite = 1'b1; hsize = 3'd2;
        end else begin
          bus_idle();
        end
        if (i > 0) begin
          hwdata = seqd[i-1];
          mdl_write(0, 32'((i - 1) * 4), 3'd2, seqd[i-1]);
        end
        @(negedge clk);
        chk("seq_ready", 32'(rdy), 32'd1);
        @(posedge clk); #1;
      end
    end
    xfer(0, 1'b0, 32'h0, 3'd2, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h4, 3'd2, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h8, 3'd2, 32'h0, 1'b0);

    // HSEL=0 and BUSY must not touch memory or stall.
    cur = 0; hsel = 3'b000; haddr = 32'h4; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    hwdata = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("nosel_ready", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    hsel = 3'b001; htrans = 2'b01;
    @(negedge clk);
    chk("busy_ready", 32'(rdy), 32'd1);
    chk("busy_resp", 32'(resp), 32'd0);
    @(posedge clk); #1;
    bus_idle();
    @(posedge clk); #1;
    xfer(0, 1'b0, 32'h4, 3'd2, 32'h0, 1'b0);

    // Byte and halfword lane merges.
    xfer(0, 1'b1, 32'h40, 3'd2, 32'h1122_3344, 1'b0);
    xfer(0, 1'b1, 32'h43, 3'd0, 32'hAA00_0000, 1'b0);
    xfer(0, 1'b0, 32'h40, 3'd2, 32'h0, 1'b0);
    xfer(0, 1'b1, 32'h40, 3'd1, 32'h0000_5566, 1'b0);
    xfer(0, 1'b0, 32'h40, 3'd2, 32'h0, 1'b0);

    // Error window: write to 0x8004 errors, alias word 0x4 keeps its contents.
    xfer(0, 1'b1, 32'h4, 3'd2, 32'h1357_9BDF, 1'b0);
    xfer(0, 1'b1, 32'h8004, 3'd2, 32'hFFFF_FFFF, 1'b1);
    xfer(0, 1'b0, 32'h4, 3'd2, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h8004, 3'd2, 32'h0, 1'b1);

    // Misaligned halfword and oversized transfer both error; memory unchanged.
    xfer(0, 1'b1, 32'h1, 3'd1, 32'hFFFF_FFFF, 1'b1);
    xfer(0, 1'b0, 32'h0, 3'd3, 32'h0, 1'b1);
    xfer(0, 1'b0, 32'h0, 3'd2, 32'h0, 1'b0);

    // WS=2: two stall cycles on write and read.
    xfer(1, 1'b1, 32'h20, 3'd2, 32'h2468_ACE0, 1'b0);
    xfer(1, 1'b0, 32'h20, 3'd2, 32'h0, 1'b0);
    // Upper address bits alias onto the same word.
    xfer(1, 1'b0, 32'hFFFF_F020, 3'd2, 32'h0, 1'b0);

    // WS=3: reset during the second wait cycle of a write abandons it.
    xfer(2, 1'b1, 32'h20, 3'd2, 32'h5A5A_1234, 1'b0);
    cur = 2; hsel = 3'b100; haddr = 32'h20; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    bus_idle();
    hwdata = 32'hDEAD_0000;
    @(posedge clk); #1;
    chk("midwait_ready", 32'(rdy), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", 32'(rdy), 32'd1);
    chk("async_rst_resp", 32'(resp), 32'd0);
    chk("async_rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(2, 1'b0, 32'h20, 3'd2, 32'h0, 1'b0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Parameters
REQ-001 ADDR_W, default 32, HADDR width.
REQ-002 DATA_W, default 32, HWDATA/HRDATA width; legal values are 32 and 64.
REQ-003 MEM_AW, default 10, word-address width; memory depth is 2**MEM_AW words of DATA_W bits.
REQ-004 WAIT_STATES, default 0, number of HREADYOUT=0 cycles inserted per OKAY transfer; range 0..15.
REQ-005 ERR_BASE, default 0, base address of the error window.
REQ-006 ERR_MASK, default 0, compare mask for the error window; 0 disables the window.

Interface
REQ-007 HCLK  input  1  clock; all state updates on the rising edge.
REQ-008 HRESETn  input  1  asynchronous, active-low reset.
REQ-009 HSEL  input  1  slave select from the decoder.
REQ-010 HADDR  input  ADDR_W  address-phase address.
REQ-011 HTRANS  input  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-012 HWRITE  input  1  1 = write, 0 = read.
REQ-013 HSIZE  input  3  transfer size in bytes, log2 encoded.
REQ-014 HBURST, HPROT  input  3, 4  accepted and ignored.
REQ-015 HWDATA  input  DATA_W  write data, valid during the data phase.
REQ-016 HREADY  input  1  global ready; qualifies address-phase acceptance.
REQ-017 HREADYOUT  output  1  slave ready; low extends the current data phase.
REQ-018 HRESP  output  2  response: 00 OKAY, 01 ERROR.
REQ-019 HRDATA  output  DATA_W  read data; valid when HREADYOUT=1 and HRESP=OKAY.

Function
REQ-020 Address-phase accept: a transfer is accepted at a rising edge where HSEL=1, HREADY=1 and HTRANS[1]=1. At acceptance, HADDR, HWRITE and HSIZE are registered.
REQ-021 IDLE or BUSY transfers, and any cycle with HSEL=0, produce no data-phase activity. HREADYOUT and HRESP stay 1/OKAY.
REQ-022 An accepted transfer is an error if any of the following holds:
- HSIZE > log2(DATA_W/8);
- HADDR is not aligned to HSIZE;
- ERR_MASK != 0 and (HADDR & ERR_MASK) == ERR_BASE.
REQ-023 FSM states are IDLE, WAIT, ERR1 and ERR2. Transitions:
- accept OKAY with WAIT_STATES > 0: go to WAIT and load the counter with WAIT_STATES;
- accept OKAY with WAIT_STATES = 0: complete in the next cycle;
- accept error: go to ERR1.
REQ-024 In WAIT, HREADYOUT=0 and HRESP=OKAY, and the counter decrements each cycle. When the counter reaches 0, the next cycle is the completion cycle with HREADYOUT=1.
REQ-025 ERR1 drives HREADYOUT=0, HRESP=ERROR for one cycle. ERR2 drives HREADYOUT=1, HRESP=ERROR for one cycle. This is the two-cycle ERROR response.
REQ-026 A write is committed at the completion edge: HWDATA is sampled at the edge where HREADYOUT=1. Only byte lanes selected by HSIZE and the low HADDR bits are updated (little-endian lanes).
REQ-027 On a read, HRDATA holds the full word at HADDR[MEM_AW+log2(DATA_W/8)-1 : log2(DATA_W/8)] during the completion cycle. HRDATA is held at its last value otherwise.
REQ-028 Upper address bits above the word index are ignored, so the memory aliases across the address space.
REQ-029 Errored transfers never modify memory. For an errored read, HRDATA = 0.
REQ-030 Pipelining: a new transfer presented during a completion cycle (HREADY=1) is accepted at the same edge, giving back-to-back transfers with no bubble. An address phase presented while HREADY=0 is not accepted.
REQ-031 A transfer accepted during ERR2 is processed normally. Per the protocol, the master is expected to present IDLE there, but the slave does not enforce this.
REQ-032 Read-after-write to the same address in consecutive transfers returns the newly written data.

Reset
REQ-033 While HRESETn=0: FSM = IDLE, HREADYOUT=1, HRESP=OKAY, HRDATA=0, wait counter = 0; memory contents are not reset.
REQ-034 Reset asserted mid-transfer (WAIT, ERR1 or ERR2) abandons the transfer and commits no memory write. The first accept after deassertion starts cleanly.

Verification
REQ-035 WAIT_STATES=0: NONSEQ write 0xDEADBEEF to 0x10 (word), then NONSEQ read from 0x10 -> HREADYOUT never low; HRDATA=0xDEADBEEF with OKAY one cycle after the read address phase.
REQ-036 WAIT_STATES=2: word read from 0x20 -> exactly 2 cycles of HREADYOUT=0, then HREADYOUT=1 with valid data.
REQ-037 Byte write 0xAA to 0x43 over word 0x11223344 -> read of 0x40 returns 0xAA223344.
REQ-038 ERR_BASE=0x8000, ERR_MASK=0xF000: write to 0x8004 -> ERR1 (HREADYOUT=0, HRESP=01), then ERR2 (HREADYOUT=1, HRESP=01); subsequent read of 0x8004's alias index returns the prior contents, unchanged.
REQ-039 Halfword access at 0x01 -> two-cycle ERROR; back-to-back SEQ writes to 0x0, 0x4, 0x8 with WAIT_STATES=0 -> all three committed with no idle cycles.
REQ-040 WAIT_STATES=3: assert HRESETn=0 during the second wait cycle of a write -> outputs return to reset values immediately; the target word is unchanged after reset release.
